apb_master_ctrl_1: RTL and testbench

APB3 transfer sequencer that sits between the AXI-to-APB front end and the five APB slaves of the axi2apb_1 bridge. It accepts one request at a time on a valid/ready interface and decodes the address through an internal `apb_addr_dec_1` instance. It then drives the SETUP/ACCESS phases to the selected slave, with wait-state and timeout handling, and returns read data plus a 2-bit response code on a valid/ready response channel. Unmapped addresses are answered with a decode error and produce no APB traffic.

---
 rtl/apb_ctrl_pkg.sv | 23 ++
 rtl/apb_addr_dec_1.sv | 25 ++
 rtl/apb_master_ctrl_1.sv | 166 ++++++++++++++++
 tb/tb_apb_master_ctrl_1.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared types for the APB transfer sequencer: FSM states, response codes and the slave address map.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] RSP_OKAY    = 2'b00;
  localparam logic [1:0] RSP_SLVERR  = 2'b01;
  localparam logic [1:0] RSP_DECERR  = 2'b10;
  localparam logic [1:0] RSP_TIMEOUT = 2'b11;

  // Slave i owns the 64 KiB page (SLV_BASE_PAGE + i) << SLV_PAGE_SHIFT.
  localparam int SLV_PAGE_SHIFT = 16;
  localparam int SLV_BASE_PAGE  = 4;

  localparam int MASTER_ID_W = 1;
  localparam int MASTER_NUM  = 1;

endpackage

// File: rtl/apb_addr_dec_1.sv
// Combinational address decoder: one select bit per slave page; no bits set for unmapped addresses.
module apb_addr_dec_1
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int SLAVE_NUM  = 5
) (
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [MASTER_ID_W-1:0] master_id,
  output logic [SLAVE_NUM-1:0]   sel
);

  logic [ADDR_WIDTH-1:0] page;
  logic                  master_ok;

  always_comb begin
    page      = addr >> SLV_PAGE_SHIFT;
    master_ok = (master_id < MASTER_ID_W'(MASTER_NUM));
    sel       = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      sel[i] = master_ok && (page == ADDR_WIDTH'(SLV_BASE_PAGE + i));
    end
  end

endmodule

// File: rtl/apb_master_ctrl_1.sv
// APB3 sequencer: one request at a time, decoded to a slave, SETUP/ACCESS with wait states and timeout,
// response returned on a valid/ready channel; unmapped addresses answer DECERR without APB traffic.
module apb_master_ctrl_1
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SLAVE_NUM      = 5,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_WIDTH  = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [DATA_WIDTH-1:0]           req_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                      rsp_code,
  output logic [ADDR_WIDTH-1:0]           paddr,
  output logic                            pwrite,
  output logic [DATA_WIDTH-1:0]           pwdata,
  output logic [SLAVE_NUM-1:0]            psel,
  output logic                            penable,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0] prdata,
  input  logic [SLAVE_NUM-1:0]            pready,
  input  logic [SLAVE_NUM-1:0]            pslverr
);

  localparam int IDX_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

  state_t                   state_q, state_d;
  logic                     write_q, write_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               code_q, code_d;

  logic [SLAVE_NUM-1:0]  dec_sel;
  logic [IDX_W-1:0]      enc_idx;
  logic                  rdy_sel;
  logic                  err_sel;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic [SLAVE_NUM-1:0]  psel_onehot;

  apb_addr_dec_1 #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .SLAVE_NUM (SLAVE_NUM)
  ) u_dec (
    .addr     (req_addr),
    .master_id(MASTER_ID_W'(0)),
    .sel      (dec_sel)
  );

  // Lowest set select bit wins; only the stored slave's APB inputs are observed.
  always_comb begin
    enc_idx = '0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if (dec_sel[i]) enc_idx = IDX_W'(i);
    end
    rdy_sel   = 1'b0;
    err_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rdy_sel   = pready[i];
        err_sel   = pslverr[i];
        rdata_sel = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    psel_onehot = SLAVE_NUM'(1) << idx_q;
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    code_d    = code_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    psel      = '0;
    penable   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          if (dec_sel == '0) begin
            code_d  = RSP_DECERR;
            state_d = RESP;
          end else begin
            code_d  = RSP_OKAY;
            idx_d   = enc_idx;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        psel    = psel_onehot;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = psel_onehot;
        penable = 1'b1;
        if (rdy_sel) begin
          code_d = err_sel ? RSP_SLVERR : RSP_OKAY;
          if (!write_q && !err_sel) rdata_d = rdata_sel;
          state_d = RESP;
        end else if (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          code_d  = RSP_TIMEOUT;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      code_q  <= RSP_OKAY;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
    end
  end

  assign paddr     = addr_q;
  assign pwrite    = write_q;
  assign pwdata    = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_code  = code_q;

endmodule

// File: tb/tb_apb_master_ctrl_1.sv
// Randomised and directed bench for apb_master_ctrl_1 with a behavioural slave and a transaction-level reference.
module tb_apb_master_ctrl_1;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 5;
  localparam int TC = 8;
  localparam int TW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_ready, req_write;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  req_wdata;
  logic           rsp_valid, rsp_ready;
  logic [DW-1:0]  rsp_rdata;
  logic [1:0]     rsp_code;
  logic [AW-1:0]  paddr;
  logic           pwrite;
  logic [DW-1:0]  pwdata;
  logic [NS-1:0]  psel;
  logic           penable;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]  pready, pslverr;

  int checks = 0;
  int errors = 0;

  apb_master_ctrl_1 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_NUM(NS),
    .TIMEOUT_CYCLES(TC), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_code(rsp_code),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Address map: slave s owns page 0x0004+s of 64 KiB pages; anything else is unmapped.
  function automatic int ref_slave(input logic [AW-1:0] a);
    int page;
    page = int'(a >> 16);
    if (page >= 4 && page <= 8) return page - 4;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One request/response transaction. waits >= TC means the slave never answers.
  task automatic do_txn(input string name, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int waits, input logic err,
                        input logic [DW-1:0] sdata, input int rdly, input logic hold_next);
    int s, exp_lat, lat, acc;
    logic [1:0] exp_code;
    logic [DW-1:0] exp_rdata;
    logic [NS-1:0] exp_psel;
    logic exp_pen;
    s = ref_slave(addr);
    if (s < 0) begin
      exp_lat = 1; exp_code = 2'b10; exp_rdata = '0; exp_psel = '0;
    end else begin
      exp_psel = NS'(1) << s;
      if (waits >= TC) begin
        exp_lat = 2 + TC; exp_code = 2'b11; exp_rdata = '0;
      end else begin
        exp_lat = 3 + waits;
        exp_code = err ? 2'b01 : 2'b00;
        exp_rdata = (!wr && !err) ? sdata : '0;
      end
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready: got %b want 1", name, req_ready);
    end
    tick();
    req_valid = 1'b0;
    lat = 0; acc = 0;
    for (int k = 1; k <= 60; k++) begin
      if (rsp_valid === 1'b1) begin lat = k; break; end
      exp_pen = (s >= 0) && (k >= 2);
      checks++;
      if (psel !== exp_psel || penable !== exp_pen) begin
        errors++;
        $display("FAIL %s apb_phase k=%0d: psel=%b penable=%b want psel=%b penable=%b",
                 name, k, psel, penable, exp_psel, exp_pen);
      end
      if (psel != '0) begin
        checks++;
        if (paddr !== addr || pwrite !== wr || pwdata !== wdata) begin
          errors++;
          $display("FAIL %s apb_bus k=%0d: paddr=%h pwrite=%b pwdata=%h want %h %b %h",
                   name, k, paddr, pwrite, pwdata, addr, wr, wdata);
        end
      end
      for (int i = 0; i < NS; i++) prdata[i*DW +: DW] = $urandom;
      pready  = NS'($urandom) & ~exp_psel;
      pslverr = NS'($urandom);
      if (s >= 0) begin
        prdata[s*DW +: DW] = sdata;
        if (penable === 1'b1) begin
          if (acc == waits) begin
            pready = pready | exp_psel;
            pslverr[s] = err;
          end
          acc++;
        end
      end
      tick();
    end
    pready = '0; pslverr = '0;
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d (0 = none)", name, lat, exp_lat);
    end
    if (lat == 0) begin
      do_reset();
      return;
    end
    checks++;
    if (rsp_code !== exp_code || rsp_rdata !== exp_rdata || psel !== '0 || penable !== 1'b0) begin
      errors++;
      $display("FAIL %s response: code=%b rdata=%h psel=%b pen=%b want code=%b rdata=%h idle bus",
               name, rsp_code, rsp_rdata, psel, penable, exp_code, exp_rdata);
    end
    for (int d = 0; d < rdly; d++) begin
      rsp_ready = 1'b0;
      if (hold_next) req_valid = 1'b1;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_code !== exp_code || rsp_rdata !== exp_rdata || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s rsp_hold d=%0d: valid=%b code=%b rdata=%h req_ready=%b want 1 %b %h 0",
                 name, d, rsp_valid, rsp_code, rsp_rdata, req_ready, exp_code, exp_rdata);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_handshake: rsp_valid=%b req_ready=%b want 0 1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = '0; pslverr = '0;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b0 || psel !== '0 || penable !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_code !== 2'b00 || rsp_rdata !== '0 || paddr !== '0 || pwdata !== '0 || pwrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: req_ready=%b psel=%b pen=%b rsp_valid=%b code=%b rdata=%h paddr=%h want all 0",
               req_ready, psel, penable, rsp_valid, rsp_code, rsp_rdata, paddr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release req_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed();
    do_txn("read_s2", 1'b0, 32'h0006_0010, 32'h0, 0, 1'b0, 32'hCAFE_0001, 0, 1'b0);
    do_txn("write_s4_slverr", 1'b1, 32'h0008_0004, 32'h1234_5678, 3, 1'b1, 32'h5555_AAAA, 0, 1'b0);
    do_txn("decerr", 1'b0, 32'h0001_0000, 32'h0, 0, 1'b0, 32'h0, 0, 1'b0);
    do_txn("timeout_s0", 1'b0, 32'h0004_0000, 32'h0, 100, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_txn("b2b_first", 1'b0, 32'h0005_0100, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 5, 1'b1);
    do_txn("b2b_second", 1'b1, 32'h0007_0200, 32'hA5A5_5A5A, 0, 1'b0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0005_0000; req_wdata = '0;
    pready = '0; pslverr = '0;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (penable !== 1'b1 || psel !== 5'b00010) begin
      errors++; $display("FAIL rst_mid access: psel=%b pen=%b want 00010 1", psel, penable);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (psel !== '0 || penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid during: psel=%b pen=%b rsp_valid=%b req_ready=%b want 0 0 0 0",
               psel, penable, rsp_valid, req_ready);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== '0) begin
      errors++;
      $display("FAIL rst_mid after: req_ready=%b rsp_valid=%b psel=%b want 1 0 0", req_ready, rsp_valid, psel);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int w;
    for (int n = 0; n < 30; n++) begin
      a = {12'h000, 4'($urandom_range(0, 11)), 16'($urandom)};
      w = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
      do_txn("random", 1'($urandom), a, $urandom, w, 1'($urandom), $urandom,
             $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
